// File: rtl/counter_src_mux_if.sv
// Signal bundle between the counter clock/data sources and the AND-OR source selector.
// master drives data/select/control; slave (the selector) drives the selected output and status.
interface counter_src_mux_if #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 2
);
    logic [CHANNELS*WIDTH-1:0] data;
    logic [CHANNELS-1:0]       sel;
    logic                      sel_strobe;
    logic                      sync_pulse;
    logic                      hold;
    logic [WIDTH-1:0]          z;
    logic [CHANNELS-1:0]       active_sel;
    logic                      pending;
    logic                      changed;

    modport master (
        output data, sel, sel_strobe, sync_pulse, hold,
        input  z, active_sel, pending, changed
    );

    modport slave (
        input  data, sel, sel_strobe, sync_pulse, hold,
        output z, active_sel, pending, changed
    );
endinterface

// File: rtl/counter_src_mux.sv
// N-channel AND-OR source selector with a latched select request that is committed
// only at a sync point, so the counter chain never sees a mid-period source change.
module counter_src_mux #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 2,
    parameter bit REGOUT   = 1'b1
) (
    input  logic               MasterClock,
    input  logic               RESETL,
    counter_src_mux_if.slave   bus
);

    typedef enum logic {IDLE, PENDING} state_e;

    state_e              state_q, state_d;
    logic [CHANNELS-1:0] pend_sel_q, pend_sel_d;
    logic [CHANNELS-1:0] act_sel_q, act_sel_d;
    logic                changed_q;
    logic                commit;
    logic [WIDTH-1:0]    zc;

    // A commit needs a captured request, a sync point and no freeze.
    assign commit = (state_q == PENDING) && bus.sync_pulse && !bus.hold;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pend_sel_d = pend_sel_q;
        act_sel_d  = act_sel_q;
        unique case (state_q)
            IDLE: begin
                if (bus.sel_strobe) begin
                    pend_sel_d = bus.sel;
                    state_d    = PENDING;
                end
            end
            PENDING: begin
                if (commit) begin
                    act_sel_d = pend_sel_q;
                    state_d   = IDLE;
                end
                if (bus.sel_strobe) begin
                    pend_sel_d = bus.sel;
                    state_d    = PENDING;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            state_q    <= IDLE;
            pend_sel_q <= '0;
            act_sel_q  <= '0;
            changed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_sel_q <= pend_sel_d;
            act_sel_q  <= act_sel_d;
            changed_q  <= commit;
        end
    end

    always_comb begin
        zc = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            zc = zc | (bus.data[i*WIDTH +: WIDTH] & {WIDTH{act_sel_q[i]}});
        end
    end

    generate
        if (REGOUT) begin : g_reg_out
            logic [WIDTH-1:0] z_q;
            always_ff @(posedge MasterClock or negedge RESETL) begin
                if (!RESETL) begin
                    z_q <= '0;
                end else if (!bus.hold) begin
                    z_q <= zc;
                end
            end
            assign bus.z = z_q;
        end else begin : g_comb_out
            assign bus.z = zc;
        end
    endgenerate

    assign bus.active_sel = act_sel_q;
    assign bus.pending    = (state_q == PENDING);
    assign bus.changed    = changed_q;

endmodule

// File: tb/tb_counter_src_mux.sv
// Directed bench for counter_src_mux (4 channels x 4 bits, registered output) against a
// rule-level reference model, plus literal spot checks that pin the model itself.
module tb_counter_src_mux;

    localparam int W = 4;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    counter_src_mux_if #(.WIDTH(W), .CHANNELS(N)) bus ();

    counter_src_mux #(.WIDTH(W), .CHANNELS(N), .REGOUT(1'b1)) dut (
        .MasterClock (clk),
        .RESETL      (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: request/commit rules applied to plain variables.
    logic [N-1:0] m_act, m_pend;
    logic         m_pending, m_changed;
    logic [W-1:0] m_z;

    function automatic logic [W-1:0] ao_select(input logic [N-1:0] mask,
                                               input logic [N*W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < N; c++)
            if (mask[c]) r = r | d[c*W +: W];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= '0; m_pend <= '0; m_pending <= 1'b0; m_changed <= 1'b0; m_z <= '0;
        end else begin
            logic do_commit;
            do_commit = m_pending && bus.sync_pulse && !bus.hold;
            m_changed <= do_commit;
            if (do_commit) m_act <= m_pend;
            if (bus.sel_strobe) m_pend <= bus.sel;
            m_pending <= bus.sel_strobe ? 1'b1 : (do_commit ? 1'b0 : m_pending);
            if (!bus.hold) m_z <= ao_select(m_act, bus.data);
        end
    end

    always @(negedge clk) begin
        check("cmp_z",       32'(bus.z),          32'(m_z));
        check("cmp_active",  32'(bus.active_sel), 32'(m_act));
        check("cmp_pending", 32'(bus.pending),    32'(m_pending));
        check("cmp_changed", 32'(bus.changed),    32'(m_changed));
    end

    // Advance to just after the next rising edge(s).
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [N-1:0] mask);
        bus.sel = mask; bus.sel_strobe = 1'b1;
        tick();
        bus.sel_strobe = 1'b0;
    endtask

    task automatic sync();
        bus.sync_pulse = 1'b1;
        tick();
        bus.sync_pulse = 1'b0;
    endtask

    initial begin
        bus.data = 16'hFFFF; bus.sel = '0; bus.sel_strobe = 1'b0;
        bus.sync_pulse = 1'b0; bus.hold = 1'b0;

        // Reset state
        tick();
        check("rst_z", 32'(bus.z), 32'h0);
        check("rst_active", 32'(bus.active_sel), 32'h0);
        check("rst_pending", 32'(bus.pending), 32'h0);
        check("rst_changed", 32'(bus.changed), 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic select: channel 0 of {8,4,2,1}
        bus.data = 16'h8421;
        strobe(4'b0001);
        check("basic_pending1", 32'(bus.pending), 32'h1);
        tick();
        check("basic_pending2", 32'(bus.pending), 32'h1);
        tick();
        check("basic_pending3", 32'(bus.pending), 32'h1);
        sync();
        check("basic_active", 32'(bus.active_sel), 32'h1);
        check("basic_changed", 32'(bus.changed), 32'h1);
        check("basic_pending_clr", 32'(bus.pending), 32'h0);
        check("basic_z_latency", 32'(bus.z), 32'h0);
        tick();
        check("basic_changed_clr", 32'(bus.changed), 32'h0);
        check("basic_z", 32'(bus.z), 32'h1);

        // SyncPulse alone in IDLE is ignored
        sync();
        check("idle_sync_changed", 32'(bus.changed), 32'h0);

        // Sel changes without strobe have no effect
        bus.sel = 4'b1111;
        tick();
        check("sel_no_strobe", 32'(bus.pending), 32'h0);

        // Multi-hot ORs channels
        strobe(4'b0101);
        sync();
        tick();
        check("multihot_z", 32'(bus.z), 32'h5);

        // Last wins, then commit-with-recapture
        strobe(4'b0001);
        strobe(4'b0010);
        bus.sel = 4'b1000; bus.sel_strobe = 1'b1; bus.sync_pulse = 1'b1;
        tick();
        bus.sel_strobe = 1'b0; bus.sync_pulse = 1'b0;
        check("lastwin_active", 32'(bus.active_sel), 32'h2);
        check("recapture_pending", 32'(bus.pending), 32'h1);
        check("recapture_changed", 32'(bus.changed), 32'h1);
        sync();
        check("second_commit_active", 32'(bus.active_sel), 32'h8);

        // Strobe+Sync in IDLE: capture only; then identical-mask commit still pulses Changed
        bus.sel = 4'b1000; bus.sel_strobe = 1'b1; bus.sync_pulse = 1'b1;
        tick();
        bus.sel_strobe = 1'b0; bus.sync_pulse = 1'b0;
        check("idle_both_changed", 32'(bus.changed), 32'h0);
        check("idle_both_pending", 32'(bus.pending), 32'h1);
        sync();
        check("same_mask_changed", 32'(bus.changed), 32'h1);
        tick();
        check("z_ch3", 32'(bus.z), 32'h8);

        // Hold freezes Z and defers commit
        strobe(4'b0001);
        bus.hold = 1'b1;
        bus.data = 16'h7777;
        sync();
        bus.data = 16'h1234;
        tick();
        check("hold_z_frozen", 32'(bus.z), 32'h8);
        check("hold_no_commit", 32'(bus.active_sel), 32'h8);
        check("hold_pending", 32'(bus.pending), 32'h1);
        bus.hold = 1'b0;
        bus.data = 16'h7777;
        tick();
        check("unhold_z", 32'(bus.z), 32'h7);
        sync();
        check("unhold_commit", 32'(bus.active_sel), 32'h1);
        tick();
        check("unhold_z_new", 32'(bus.z), 32'h7);

        // Reset mid-op discards pending request; asynchronous clear seen immediately
        bus.data = 16'hFFFF;
        strobe(4'b0100);
        tick();
        check("pre_reset_z", 32'(bus.z), 32'hF);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_z", 32'(bus.z), 32'h0);
        check("async_rst_active", 32'(bus.active_sel), 32'h0);
        check("async_rst_pending", 32'(bus.pending), 32'h0);
        tick();
        rst_n = 1'b1;
        sync();
        check("post_rst_active", 32'(bus.active_sel), 32'h0);
        check("post_rst_changed", 32'(bus.changed), 32'h0);
        tick(2);
        check("post_rst_z", 32'(bus.z), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
